// File: rtl/lstm_pkg.sv
// rtl/lstm_pkg.sv - shared state and gate-index constants for the LSTM gate sequencer
package lstm_pkg;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_ISSUE = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_STEP  = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_ISSUE = ST_ISSUE,
    S_WAIT  = ST_WAIT,
    S_STEP  = ST_STEP,
    S_DONE  = ST_DONE
  } sched_state_t;

  localparam logic [1:0] GATE_I = 2'd0;
  localparam logic [1:0] GATE_F = 2'd1;
  localparam logic [1:0] GATE_O = 2'd2;
  localparam logic [1:0] GATE_C = 2'd3;

endpackage

// File: rtl/sched_watchdog.sv
// rtl/sched_watchdog.sv - per-gate wait counter; expired marks the TIMEOUT_CYCLES-th counted cycle
module sched_watchdog #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic count,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clock) begin
    if (reset || clear)
      cnt <= '0;
    else if (count && cnt != CW'(TIMEOUT_CYCLES))
      cnt <= cnt + CW'(1);
  end

  assign expired = count && (cnt == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/lstm_gate_sched.sv
// rtl/lstm_gate_sched.sv - time-multiplexes one gate datapath over I/F/O/C per timestep; GATE_SCHED_TIMEOUT_EN adds a per-gate watchdog
module lstm_gate_sched
  import lstm_pkg::*;
#(
  parameter int NUM_STEPS_W    = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   start,
  input  logic [NUM_STEPS_W-1:0] numSteps,
  input  logic                   dataReady_gate,
  input  logic                   cellDone,
  output logic                   beginCalc,
  output logic [1:0]             gateSel,
  output logic [3:0]             captureEn,
  output logic                   gatesValid,
  output logic                   firstStep,
  output logic [NUM_STEPS_W-1:0] stepCount,
  output logic                   busy,
  output logic                   done,
  output logic                   error
);

  sched_state_t           state;
  logic [1:0]             g;
  logic [NUM_STEPS_W-1:0] step;
  logic [NUM_STEPS_W-1:0] len;

`ifdef GATE_SCHED_TIMEOUT_EN
  logic wd_expired;
  logic error_q;

  sched_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clock   (clock),
    .reset   (reset),
    .clear   (state == S_ISSUE),
    .count   (state == S_WAIT),
    .expired (wd_expired)
  );

  assign error = error_q;
`else
  // watchdog not built: constant 0 for any legal (positive) limit
  assign error = (TIMEOUT_CYCLES < 0);
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= S_IDLE;
      g     <= GATE_I;
      step  <= '0;
      len   <= '0;
`ifdef GATE_SCHED_TIMEOUT_EN
      error_q <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            len   <= (numSteps == '0) ? NUM_STEPS_W'(1) : numSteps;
            step  <= '0;
            g     <= GATE_I;
            state <= S_ISSUE;
          end
        end
        S_ISSUE: state <= S_WAIT;
        S_WAIT: begin
          if (dataReady_gate) begin
            if (g == GATE_C) begin
              state <= S_STEP;
            end else begin
              g     <= g + 2'd1;
              state <= S_ISSUE;
            end
          end
`ifdef GATE_SCHED_TIMEOUT_EN
          else if (wd_expired) begin
            error_q <= 1'b1;
            state   <= S_DONE;
          end
`endif
        end
        S_STEP: begin
          if (cellDone) begin
            if (step + NUM_STEPS_W'(1) == len) begin
              state <= S_DONE;
            end else begin
              step  <= step + NUM_STEPS_W'(1);
              g     <= GATE_I;
              state <= S_ISSUE;
            end
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // gateOutput is valid in the ready cycle, so the strobe is a direct decode; masked during reset
  assign captureEn  = (state == S_WAIT && dataReady_gate && !reset) ? (4'b0001 << g) : 4'b0000;
  assign beginCalc  = (state == S_ISSUE);
  assign gatesValid = (state == S_STEP);
  assign done       = (state == S_DONE);
  assign busy       = (state != S_IDLE);
  assign gateSel    = (state == S_ISSUE || state == S_WAIT || state == S_STEP) ? g : 2'd0;
  assign stepCount  = step;
  assign firstStep  = busy && (step == '0);

endmodule

// File: tb/tb_lstm_gate_sched.sv
// tb/tb_lstm_gate_sched.sv - randomized scoreboard bench for lstm_gate_sched
module tb_lstm_gate_sched;

  localparam int NW = 8;
`ifdef GATE_SCHED_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 4096;
`endif

  logic          clock = 1'b0;
  logic          reset, start, dataReady_gate, cellDone;
  logic [NW-1:0] numSteps;
  logic          beginCalc, gatesValid, firstStep, busy, done, error;
  logic [1:0]    gateSel;
  logic [3:0]    captureEn;
  logic [NW-1:0] stepCount;

  lstm_gate_sched #(.NUM_STEPS_W(NW), .TIMEOUT_CYCLES(TO)) dut (
    .clock          (clock),
    .reset          (reset),
    .start          (start),
    .numSteps       (numSteps),
    .dataReady_gate (dataReady_gate),
    .cellDone       (cellDone),
    .beginCalc      (beginCalc),
    .gateSel        (gateSel),
    .captureEn      (captureEn),
    .gatesValid     (gatesValid),
    .firstStep      (firstStep),
    .stepCount      (stepCount),
    .busy           (busy),
    .done           (done),
    .error          (error)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int exp_begin[$];
  int exp_cap[$];
  int exp_done[$];
  int cur_step = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] all_outputs();
    return 32'({beginCalc, gateSel, captureEn, gatesValid, firstStep, stepCount, busy, done, error});
  endfunction

  // monitor: pops expectations whenever the DUT presents an event
  int e_mon;
  always @(negedge clock) begin
    if (!reset) begin
      if (beginCalc) begin
        if (exp_begin.size() == 0) check("unexpected_begin", 1, 0);
        else begin
          e_mon = exp_begin.pop_front();
          check("begin_step_gate", int'(stepCount) * 4 + int'(gateSel), e_mon);
        end
      end
      if (captureEn != 4'b0) begin
        if (exp_cap.size() == 0) check("unexpected_capture", 32'(captureEn), 0);
        else begin
          e_mon = exp_cap.pop_front();
          check("capture_onehot", 32'(captureEn), e_mon);
        end
      end
      if (done) begin
        if (exp_done.size() == 0) check("unexpected_done", 1, 0);
        else begin
          e_mon = exp_done.pop_front();
          check("done_step", 32'(stepCount), e_mon);
        end
      end
      if (busy) begin
        check("step_count", 32'(stepCount), cur_step);
        check("first_step", 32'(firstStep), 32'(cur_step == 0));
      end
    end
  end

  // glat/clat < 0 pick random latencies; abort_s/abort_g select a mid-sequence reset point
  task automatic run_seq(input int n, input bit spur, input bit hold_any,
                         input int glat, input int clat, input int abort_s, input int abort_g);
    int  neff, lat;
    bit  hold;
    neff = (n == 0) ? 1 : n;
    for (int s = 0; s < neff; s++)
      for (int g = 0; g < 4; g++) begin
        exp_begin.push_back(s * 4 + g);
        exp_cap.push_back(1 << g);
      end
    exp_done.push_back(neff - 1);
    cur_step = 0;
    numSteps = NW'(n);
    start = 1'b1;
    tick;
    start = 1'b0;
    numSteps = NW'($urandom);
    check("start_to_begin", 32'(beginCalc), 1);
    for (int s = 0; s < neff; s++) begin
      for (int g = 0; g < 4; g++) begin
        tick;
        dataReady_gate = 1'b0;
        lat = (glat < 0) ? int'($urandom_range(0, 6)) : glat;
        repeat (lat) begin
          if (spur) begin
            start    = 1'($urandom_range(0, 1));
            cellDone = 1'($urandom_range(0, 1));
          end
          tick;
        end
        start    = 1'b0;
        cellDone = 1'b0;
        if (s == abort_s && g == abort_g) begin
          reset = 1'b1;
          dataReady_gate = 1'b1;
          #1;
          check("capture_in_reset", 32'(captureEn), 0);
          tick;
          reset = 1'b0;
          dataReady_gate = 1'b0;
          #1;
          check("reset_outputs", all_outputs(), 0);
          exp_begin.delete();
          exp_cap.delete();
          exp_done.delete();
          return;
        end
        dataReady_gate = 1'b1;
        hold = hold_any && ($urandom_range(0, 1) == 1);
        tick;
        if (!hold) dataReady_gate = 1'b0;
        if (g < 3) check("ready_to_begin", 32'({beginCalc, gateSel}), 32'({1'b1, 2'(g + 1)}));
        else       check("ready_to_valid", 32'(gatesValid), 1);
      end
      tick;
      dataReady_gate = 1'b0;
      lat = (clat < 0) ? int'($urandom_range(0, 5)) : clat;
      repeat (lat) begin
        if (spur) dataReady_gate = 1'($urandom_range(0, 1));
        tick;
      end
      dataReady_gate = 1'b0;
      cellDone = 1'b1;
      tick;
      cellDone = 1'b0;
      if (s == neff - 1) begin
        check("cell_to_done", 32'({done, busy}), 32'(2'b11));
        tick;
        check("idle_after_done", 32'({done, busy}), 0);
      end else begin
        cur_step = s + 1;
        check("cell_to_begin", 32'(beginCalc), 1);
      end
    end
    tick;
    check("queues_drained", exp_begin.size() + exp_cap.size() + exp_done.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "bench time limit");
  end

  initial begin
    int nb;
    reset = 1'b1;
    start = 1'b0;
    numSteps = '0;
    dataReady_gate = 1'b0;
    cellDone = 1'b0;
    repeat (3) tick;
    reset = 1'b0;
    check("reset_state", all_outputs(), 0);
    tick;

    run_seq(1, 0, 0, 19, 4, -1, -1);
    run_seq(3, 0, 0, -1, -1, -1, -1);
    run_seq(0, 0, 0, 19, 4, -1, -1);
    run_seq(3, 1, 1, -1, -1, -1, -1);
    run_seq(3, 0, 0, -1, -1, 1, 2);
    run_seq(1, 0, 0, -1, -1, -1, -1);
    for (int i = 0; i < 6; i++)
      run_seq(int'($urandom_range(1, 4)), 1, 1, -1, -1, -1, -1);
    check("no_error", 32'(error), 0);

`ifdef GATE_SCHED_TIMEOUT_EN
    cur_step = 0;
    exp_begin.push_back(0);
    exp_done.push_back(0);
    numSteps = NW'(1);
    start = 1'b1;
    tick;
    start = 1'b0;
    tick;
    repeat (TO - 1) tick;
    check("wd_last_wait", 32'({busy, done, error}), 32'(3'b100));
    tick;
    check("wd_done", 32'({done, error}), 32'(2'b11));
    tick;
    check("wd_idle", 32'({busy, error}), 32'(2'b01));
    reset = 1'b1;
    tick;
    reset = 1'b0;
    check("wd_reset_clears", 32'(error), 0);
`else
    cur_step = 0;
    exp_begin.push_back(0);
    numSteps = NW'(1);
    start = 1'b1;
    tick;
    start = 1'b0;
    nb = 0;
    repeat (1000) begin
      tick;
      if (busy) nb++;
    end
    check("no_timeout_busy", nb, 1000);
    check("no_timeout_error", 32'(error), 0);
    reset = 1'b1;
    tick;
    reset = 1'b0;
    exp_begin.delete();
    check("idle_after_reset", all_outputs(), 0);
`endif
    tick;
    check("final_queues", exp_begin.size() + exp_cap.size() + exp_done.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
